// File: rtl/mul_by_add_pkg.sv
// Shared definitions for the shift-free multiplier that rebuilds N = Q*P + R by repeated addition.
package mul_by_add_pkg;
   localparam int W_DEFAULT = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADQ,
      S_LOADP,
      S_LOADR,
      S_ADD,
      S_ADDR,
      S_DONE
   } state_t;
endpackage

// File: rtl/mul_by_add_ctrl.sv
// Controller for mul_by_add: state register with registered strobe, Busy and Done flags.
// Start is only honoured from IDLE or DONE; the add strobe is qualified by the datapath's Q==0 flag.
module mul_by_add_ctrl
   import mul_by_add_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_qz,
   output logic o_clr,
   output logic o_load_q,
   output logic o_load_p,
   output logic o_load_r,
   output logic o_add,
   output logic o_add_r,
   output logic o_busy,
   output logic o_done
);

   state_t r_state;
   logic   r_load_q;
   logic   r_load_p;
   logic   r_load_r;
   logic   r_add_st;
   logic   r_addr_st;
   logic   r_busy;
   logic   r_done;

   assign o_clr    = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
   assign o_load_q = r_load_q;
   assign o_load_p = r_load_p;
   assign o_load_r = r_load_r;
   assign o_add    = r_add_st & ~i_qz;
   assign o_add_r  = r_addr_st;
   assign o_busy   = r_busy;
   assign o_done   = r_done;

   // Each flag is written together with the state it decodes, so outputs track r_state exactly.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_load_q  <= 1'b0;
         r_load_p  <= 1'b0;
         r_load_r  <= 1'b0;
         r_add_st  <= 1'b0;
         r_addr_st <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state  <= S_LOADQ;
                  r_load_q <= 1'b1;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end
            S_LOADQ: begin
               r_state  <= S_LOADP;
               r_load_q <= 1'b0;
               r_load_p <= 1'b1;
            end
            S_LOADP: begin
               r_state  <= S_LOADR;
               r_load_p <= 1'b0;
               r_load_r <= 1'b1;
            end
            S_LOADR: begin
               r_state  <= S_ADD;
               r_load_r <= 1'b0;
               r_add_st <= 1'b1;
            end
            S_ADD: begin
               if (i_qz) begin
                  r_state   <= S_ADDR;
                  r_add_st  <= 1'b0;
                  r_addr_st <= 1'b1;
               end
            end
            S_ADDR: begin
               r_state   <= S_DONE;
               r_addr_st <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               r_load_q  <= 1'b0;
               r_load_p  <= 1'b0;
               r_load_r  <= 1'b0;
               r_add_st  <= 1'b0;
               r_addr_st <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mul_by_add.sv
// Rebuilds a dividend N = Q*P + R by adding P to an accumulator Q times, then adding R.
// Latency: Done rises Q+5 cycles after the accepting Start edge; Result holds until the next Start.
module mul_by_add
   import mul_by_add_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_start,
   input  logic [W-1:0]   i_data_in,
   output logic           o_load_q,
   output logic           o_load_p,
   output logic           o_load_r,
   output logic           o_busy,
   output logic           o_done,
   output logic [2*W-1:0] o_result
);

   logic [W-1:0]   r_q;
   logic [W-1:0]   r_p;
   logic [W-1:0]   r_r;
   logic [2*W-1:0] r_acc;

   logic w_qz;
   logic w_clr;
   logic w_load_q;
   logic w_load_p;
   logic w_load_r;
   logic w_add;
   logic w_add_r;

   assign w_qz     = (r_q == '0);
   assign o_load_q = w_load_q;
   assign o_load_p = w_load_p;
   assign o_load_r = w_load_r;
   assign o_result = r_acc;

   mul_by_add_ctrl u_ctrl (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (i_start),
      .i_qz     (w_qz),
      .o_clr    (w_clr),
      .o_load_q (w_load_q),
      .o_load_p (w_load_p),
      .o_load_r (w_load_r),
      .o_add    (w_add),
      .o_add_r  (w_add_r),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   // The accumulator is twice the operand width, so zero-extended sums never wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q   <= '0;
         r_p   <= '0;
         r_r   <= '0;
         r_acc <= '0;
      end else begin
         if (w_load_q) begin
            r_q <= i_data_in;
         end else if (w_add) begin
            r_q <= r_q - W'(1);
         end
         if (w_load_p) begin
            r_p <= i_data_in;
         end
         if (w_load_r) begin
            r_r <= i_data_in;
         end
         if (w_clr) begin
            r_acc <= '0;
         end else if (w_add) begin
            r_acc <= r_acc + {{W{1'b0}}, r_p};
         end else if (w_add_r) begin
            r_acc <= r_acc + {{W{1'b0}}, r_r};
         end
      end
   end

endmodule

// File: tb/tb_mul_by_add.sv
// Bench for mul_by_add: expected results and latencies are queued when an operation is launched.
module tb_mul_by_add;

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_data_in = 8'd0;
   logic        o_load_q;
   logic        o_load_p;
   logic        o_load_r;
   logic        o_busy;
   logic        o_done;
   logic [15:0] o_result;

   int total = 0;
   int bad = 0;
   int exp_res_q[$];
   int exp_lat_q[$];

   always #5 clk = ~clk;

   mul_by_add #(.W(8)) dut (
      .i_clk     (clk),
      .i_rst_n   (i_rst_n),
      .i_start   (i_start),
      .i_data_in (i_data_in),
      .o_load_q  (o_load_q),
      .o_load_p  (o_load_p),
      .o_load_r  (o_load_r),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_result  (o_result)
   );

   // Called at a falling edge; returns at the falling edge where Done is first seen.
   task automatic run_op(input int q, input int p, input int r, input bit hold,
                         input int pulse_at, input int abort_at,
                         output logic [31:0] res, output int lat, output bit busy_ok,
                         output bit to, output bit aborted);
      exp_res_q.push_back(q * p + r);
      exp_lat_q.push_back(q + 5);
      busy_ok = 1'b1;
      to      = 1'b1;
      aborted = 1'b0;
      lat     = -1;
      res     = 'x;
      i_start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!hold) i_start = 1'b0;
         if (n == pulse_at) i_start = 1'b1;
         if (n == abort_at) begin
            i_rst_n = 1'b0;
            i_start = 1'b0;
            aborted = 1'b1;
            to      = 1'b0;
            return;
         end
         if (o_done === 1'b1) begin
            lat = n;
            res = 32'(o_result);
            to  = 1'b0;
            return;
         end
         if (o_busy !== 1'b1) busy_ok = 1'b0;
         if (o_load_q === 1'b1) i_data_in = q[7:0];
         if (o_load_p === 1'b1) i_data_in = p[7:0];
         if (o_load_r === 1'b1) i_data_in = r[7:0];
      end
   endtask

   task automatic test_reset();
      logic [4:0] flags;
      repeat (3) @(negedge clk);
      flags = {o_busy, o_done, o_load_q, o_load_p, o_load_r};
      total++;
      if (flags !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 00000", flags);
      end
      total++;
      if (o_result !== 16'd0) begin
         bad++;
         $display("FAIL reset_result: got %0d want 0", o_result);
      end
      i_rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] res; int lat; bit bok, to, ab; int er, el;
      run_op(2, 23, 7, 1'b0, -1, -1, res, lat, bok, to, ab);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      total++;
      if (to) begin bad++; $display("FAIL basic_timeout: no Done within 400 cycles"); end
      total++;
      if (res !== 32'(er)) begin bad++; $display("FAIL basic_result: got %0d want %0d", res, er); end
      total++;
      if (lat != el) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, el); end
      total++;
      if (!bok) begin bad++; $display("FAIL basic_busy: got busy low during op want high"); end
      @(negedge clk);
      total++;
      if ({o_done, o_busy, o_result} !== {1'b1, 1'b0, 16'd53}) begin
         bad++;
         $display("FAIL basic_hold: got done=%b busy=%b res=%0d want done=1 busy=0 res=53",
                  o_done, o_busy, o_result);
      end
   endtask

   task automatic test_zero_operands();
      logic [31:0] res; int lat; bit bok, to, ab; int er, el;
      int ops[3][3] = '{'{0, 14, 0}, '{0, 31, 21}, '{3, 0, 9}};
      for (int k = 0; k < 3; k++) begin
         run_op(ops[k][0], ops[k][1], ops[k][2], 1'b0, -1, -1, res, lat, bok, to, ab);
         er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
         total++;
         if (to || res !== 32'(er)) begin
            bad++;
            $display("FAIL zero_result[%0d]: got %0d (timeout=%0b) want %0d", k, res, to, er);
         end
         total++;
         if (lat != el) begin bad++; $display("FAIL zero_latency[%0d]: got %0d want %0d", k, lat, el); end
      end
   endtask

   task automatic test_max();
      logic [31:0] res; int lat; bit bok, to, ab; int er, el;
      run_op(255, 255, 255, 1'b0, -1, -1, res, lat, bok, to, ab);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      total++;
      if (to || res !== 32'(er)) begin
         bad++;
         $display("FAIL max_result: got %0d (timeout=%0b) want %0d", res, to, er);
      end
      total++;
      if (lat != el) begin bad++; $display("FAIL max_latency: got %0d want %0d", lat, el); end
   endtask

   task automatic test_start_busy();
      logic [31:0] res; int lat; bit bok, to, ab; int er, el;
      run_op(16, 15, 10, 1'b0, 8, -1, res, lat, bok, to, ab);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      total++;
      if (to || res !== 32'(er)) begin
         bad++;
         $display("FAIL busy_start_result: got %0d (timeout=%0b) want %0d", res, to, er);
      end
      total++;
      if (lat != el) begin bad++; $display("FAIL busy_start_latency: got %0d want %0d", lat, el); end
      total++;
      if (!bok) begin bad++; $display("FAIL busy_start_busy: got busy low during op want high"); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res; int lat; bit bok, to, ab; int er, el;
      run_op(5, 11, 4, 1'b0, -1, 6, res, lat, bok, to, ab);
      void'(exp_res_q.pop_front()); void'(exp_lat_q.pop_front());
      #1;
      total++;
      if (!ab) begin bad++; $display("FAIL midreset_reached: got done before abort point want abort"); end
      total++;
      if ({o_busy, o_done, o_load_q, o_load_p, o_load_r, o_result} !== 21'd0) begin
         bad++;
         $display("FAIL midreset_clear: got busy=%b done=%b res=%0d want all zero",
                  o_busy, o_done, o_result);
      end
      @(negedge clk);
      i_rst_n = 1'b1;
      run_op(5, 11, 4, 1'b0, -1, -1, res, lat, bok, to, ab);
      er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
      total++;
      if (to || res !== 32'(er)) begin
         bad++;
         $display("FAIL midreset_rerun: got %0d (timeout=%0b) want %0d", res, to, er);
      end
      total++;
      if (lat != el) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, el); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res; int lat; bit bok, to, ab; int er, el;
      int ops[2][3] = '{'{5, 3, 1}, '{1, 234, 0}};
      for (int k = 0; k < 2; k++) begin
         run_op(ops[k][0], ops[k][1], ops[k][2], 1'b1, -1, -1, res, lat, bok, to, ab);
         er = exp_res_q.pop_front(); el = exp_lat_q.pop_front();
         total++;
         if (to || res !== 32'(er)) begin
            bad++;
            $display("FAIL b2b_result[%0d]: got %0d (timeout=%0b) want %0d", k, res, to, er);
         end
         total++;
         if (lat != el) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, lat, el); end
      end
      i_data_in = 8'd0;
      @(negedge clk);
      i_start = 1'b0;
      total++;
      if ({o_done, o_load_q} !== 2'b01) begin
         bad++;
         $display("FAIL b2b_done_pulse: got done=%b loadq=%b want done=0 loadq=1", o_done, o_load_q);
      end
      repeat (8) @(negedge clk);
      total++;
      if (exp_res_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_res_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_operands();
      test_max();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_by_add.md
MUL_BY_ADD -- requirements
Module: mul_by_add

Interface
REQ-001 Parameter W, default 8, width of the Data_in operands.
REQ-002 Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  begin an operation; sampled only in IDLE or DONE.
REQ-005 Data_in  input  W  operand bus, carrying Q, then P, then R on consecutive cycles.
REQ-006 LoadQ  output  1  high in state LOADQ; Data_in is captured into Q at the end of this cycle.
REQ-007 LoadP  output  1  high in state LOADP; Data_in is captured into P at the end of this cycle.
REQ-008 LoadR  output  1  high in state LOADR; Data_in is captured into R at the end of this cycle.
REQ-009 Busy  output  1  high in every state except IDLE and DONE.
REQ-010 Done  output  1  high in state DONE.
REQ-011 Result  output  2W  reconstructed dividend N = Q*P + R.

Function
REQ-012 States: IDLE, LOADQ, LOADP, LOADR, ADD, ADDR, DONE.
REQ-013 Transitions:
- IDLE/DONE with Start=1 -> LOADQ; accumulator cleared to 0.
- Start=0 in IDLE/DONE: state holds.
- LOADQ -> LOADP -> LOADR -> ADD, unconditionally.
REQ-014 ADD, per cycle:
- Q != 0: ACC <= ACC + P, Q <= Q - 1, stay in ADD.
- Q == 0: go to ADDR with no addition.
REQ-015 ADDR: ACC <= ACC + R; next state DONE.
REQ-016 Result is driven directly from ACC (2W bits). Additions are zero-extended, unsigned and cannot overflow, since max 255*255+255 = 65280.
REQ-017 Latency: with Start sampled at edge 0, Done rises after edge Q+5; total = Q+5 cycles.
REQ-018 Start is ignored while Busy=1; no restart and no effect on operands.
REQ-019 Result holds its value in DONE until the next accepted Start clears ACC.
REQ-020 P=0 or Q=0: Result = R, with no special-casing beyond REQ-014.
REQ-021 Start held continuously high: DONE lasts exactly one cycle before the next LOADQ.
REQ-022 Every output is a registered-state decode or register; there is no combinational path from inputs to outputs.

Reset
REQ-023 Rst_n=0 asynchronously forces:
- state IDLE;
- Q, P, R, ACC = 0;
- Result = 0;
- Busy, Done, LoadQ, LoadP, LoadR = 0.
REQ-024 Reset mid-operation abandons the operation; no partial Result is retained.
REQ-025 The first accepted Start after reset deassertion behaves per REQ-013.

Structure
REQ-026 Shared package mul_by_add_pkg holds the state enumeration and the default width constant W=8.
REQ-027 Controller (state register plus strobe/Busy/Done decode) is sub-module mul_by_add_ctrl.
REQ-028 Datapath (Q down-counter, P, R, ACC, adder, Q==0 compare) stays in mul_by_add.
REQ-029 mul_by_add_ctrl receives Qz (Q==0) from the datapath and returns the load/add strobes.

Verification
REQ-030 Basic case: Start, then Q=2, P=23, R=7 on LoadQ/LoadP/LoadR cycles -> Result=53, Done after 7 cycles, Busy=1 throughout operation.
REQ-031 Zero quotient: Q=0, P=14, R=0 -> Result=0, Done after 5 cycles; then Q=0, P=31, R=21 -> Result=21.
REQ-032 Maximum operands: Q=255, P=255, R=255 -> Result=65280, Done after 260 cycles, no wrap.
REQ-033 Start during busy: Q=16, P=15, R=10; pulse Start during ADD -> ignored, Result=250, Done after 21 cycles.
REQ-034 Reset mid-operation: Rst_n low during ADD of Q=5, P=11, R=4 -> immediately IDLE, Result=0; rerun -> Result=59.
REQ-035 Back-to-back: Start held high across two operations (5,3,1) then (1,234,0) -> Done pulses one cycle each; Results 16 then 234.
